// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
// ALU_MUL_RADIX4_EN selects radix-4 recoding (16 iterations) instead of radix-2 (32 iterations).
package alu_pkg;

  localparam int WIDTH    = 32;
  localparam int ITERS_R4 = 16;
  localparam int ITERS_R2 = 32;

`ifdef ALU_MUL_RADIX4_EN
  localparam int STEP  = 2;
  localparam int ITERS = ITERS_R4;
`else
  localparam int STEP  = 1;
  localparam int ITERS = ITERS_R2;
`endif

  // Recoder window: STEP multiplier bits plus the implicit bit below them.
  localparam int WIN_W = STEP + 1;

  typedef enum logic [2:0] {
    ZERO,
    PLUS_M,
    MINUS_M,
    PLUS_2M,
    MINUS_2M
  } booth_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/alu_mul_booth_if.sv
// Start/operand/result bundle between the ALU control unit and the Booth multiplier.
interface alu_mul_booth_if #(
  parameter int WIDTH = alu_pkg::WIDTH
);
  logic                    start;
  logic signed [WIDTH-1:0] A;
  logic signed [WIDTH-1:0] B;
  logic signed [WIDTH-1:0] P;
  logic signed [WIDTH-1:0] P_hi;
  logic                    busy;
  logic                    done;

  modport master (
    output start, A, B,
    input  P, P_hi, busy, done
  );

  modport slave (
    input  start, A, B,
    output P, P_hi, busy, done
  );
endinterface

// File: rtl/booth_recoder.sv
// Maps a multiplier window onto a Booth digit; radix set by ALU_MUL_RADIX4_EN.
module booth_recoder
  import alu_pkg::*;
(
  input  logic [WIN_W-1:0] win,
  output booth_digit_t     digit
);

  always_comb begin
    digit = ZERO;
`ifdef ALU_MUL_RADIX4_EN
    case (win)
      3'b001, 3'b010: digit = PLUS_M;
      3'b011:         digit = PLUS_2M;
      3'b100:         digit = MINUS_2M;
      3'b101, 3'b110: digit = MINUS_M;
      default:        digit = ZERO;
    endcase
`else
    case (win)
      2'b01:   digit = PLUS_M;
      2'b10:   digit = MINUS_M;
      default: digit = ZERO;
    endcase
`endif
  end

endmodule

// File: rtl/alu_mul_booth.sv
// Sequential signed WIDTHxWIDTH Booth multiplier producing {P_hi, P}.
// ALU_MUL_RADIX4_EN selects radix-4 (16 iterations); otherwise radix-2 (32 iterations).
module alu_mul_booth
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_mul_booth_if.slave bus
);

  localparam int ACC_W = WIDTH + 2;
  localparam int CNT_W = $clog2(ITERS);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic                    last;
  logic                    done_r;
  logic signed [WIDTH-1:0] p_lo, p_hi;

  logic signed [WIDTH-1:0]       mcand;
  logic signed [ACC_W-1:0]       acc_hi;
  logic [WIDTH-1:0]              acc_lo;
  logic                          q;
  logic [WIN_W-1:0]              win;
  booth_digit_t                  digit;
  logic signed [ACC_W-1:0]       m_ext, addend, sum;
  logic signed [ACC_W+WIDTH-1:0] shifted;

  assign last     = (cnt == CNT_W'(ITERS - 1));
  assign bus.busy = (state == RUN);
  assign bus.done = done_r;
  assign bus.P    = p_lo;
  assign bus.P_hi = p_hi;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      done_r <= 1'b0;
      p_lo   <= '0;
      p_hi   <= '0;
    end else begin
      done_r <= (state == DONE);
      if (state == IDLE && bus.start) cnt <= '0;
      else if (state == RUN)          cnt <= cnt + 1'b1;
      if (state == DONE) begin
        p_hi <= acc_hi[WIDTH-1:0];
        p_lo <= acc_lo;
      end
    end
  end

  // The multiplier shifts out of acc_lo as product bits shift in from acc_hi.
  assign win = {acc_lo[STEP-1:0], q};

  booth_recoder u_recoder (
    .win   (win),
    .digit (digit)
  );

  // Two guard bits in acc_hi absorb +/-2M on top of the running partial sum.
  always_comb begin
    m_ext  = $signed({{(ACC_W-WIDTH){mcand[WIDTH-1]}}, mcand});
    addend = '0;
    case (digit)
      PLUS_M:   addend = m_ext;
      MINUS_M:  addend = -m_ext;
      PLUS_2M:  addend = m_ext <<< 1;
      MINUS_2M: addend = -(m_ext <<< 1);
      default:  addend = '0;
    endcase
    sum     = acc_hi + addend;
    shifted = $signed({sum, acc_lo}) >>> STEP;
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      mcand  <= bus.A;
      acc_hi <= '0;
      acc_lo <= bus.B;
      q      <= 1'b0;
    end else if (state == RUN) begin
      acc_hi <= shifted[ACC_W+WIDTH-1:WIDTH];
      acc_lo <= shifted[WIDTH-1:0];
      q      <= acc_lo[STEP-1];
    end
  end

endmodule

// File: tb/tb_alu_mul_booth.sv
// Scoreboard bench for alu_mul_booth: expected products queued at start, checked on done.
module tb_alu_mul_booth;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [63:0] sb[$];
  logic [63:0] last_exp = 64'h0;

  alu_mul_booth_if bus ();

  alu_mul_booth dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Every done pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) check("spurious_done", 64'd1, 64'd0);
      else                check("product", {bus.P_hi, bus.P}, sb.pop_front());
    end
  end

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sbv;
    sa  = 64'($signed(a));
    sbv = 64'($signed(b));
    return sa * sbv;
  endfunction

  task automatic mul(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                     input bit inject);
    int lat;
    lat = 0;
    @(negedge clk);
    bus.A = a; bus.B = b; bus.start = 1'b1;
    sb.push_back(exp);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_start", {63'd0, bus.busy}, 64'd1);
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (inject && k == 3) begin
        bus.A = 32'h1234_5678; bus.B = 32'h7654_3210; bus.start = 1'b1;
      end
      if (inject && k == 4) bus.start = 1'b0;
      if (k == ITERS) check("p_hold", {bus.P_hi, bus.P}, last_exp);
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("latency", 64'(lat), 64'(ITERS + 1));
    check("busy_done", {63'd0, bus.busy}, 64'd0);
    last_exp = exp;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.A = '0; bus.B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_p",    {32'd0, bus.P},    64'd0);
    check("rst_p_hi", {32'd0, bus.P_hi}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    rst_n = 1'b1;

    mul(32'h0000_008B, 32'hFFFF_FF74, 64'hFFFF_FFFF_FFFF_B3FC, 1'b0);
    mul(32'hFFFF_FB26, 32'h0000_008C, 64'hFFFF_FFFF_FFFD_58C8, 1'b0);
    mul(32'hFFFF_FF10, 32'hFFFF_FF7B, 64'h0000_0000_0000_7CB0, 1'b0);
    mul(32'h0007_B4DA, 32'h0000_5DEC, 64'h0000_0002_D3CD_EAF8, 1'b0);
    mul(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
    mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
    mul(32'h0000_0000, 32'hDEAD_BEEF, 64'h0, 1'b0);
    mul(32'h1357_9BDF, 32'h0000_0000, 64'h0, 1'b0);
    mul(32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 1'b0);
    // Start pulsed mid-run with different operands must not disturb the first product.
    mul(32'h0000_1234, 32'hFFFF_F000, model(32'h0000_1234, 32'hFFFF_F000), 1'b1);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      mul(ra, rb, model(ra, rb), 1'b0);
    end

    // Reset at cycle 5 of a run aborts it with no done.
    @(negedge clk);
    bus.A = 32'h0000_01F9; bus.B = 32'h0000_00F0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_p",    {32'd0, bus.P},    64'd0);
    check("abort_p_hi", {32'd0, bus.P_hi}, 64'd0);
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_done", {63'd0, bus.done}, 64'd0);
    rst_n = 1'b1;
    last_exp = 64'h0;
    repeat (ITERS + 4) @(posedge clk);
    mul(32'h0000_01F9, 32'h0000_00F0, 64'h0000_0000_0001_D970, 1'b0);

    repeat (ITERS + 4) @(posedge clk);
    #1;
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
